// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse frame generator: FSM states, pulse shape,
// saturating add and LFSR step.
package pulse_gen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSeed,
    StRd,
    StWait,
    StWr,
    StDone
  } state_e;

  // Sample k of the decaying pulse shape.
  function automatic logic [63:0] pulse_sample(input logic [63:0] peak, input int unsigned k);
    return peak >> k;
  endfunction

  // Add clamped to the largest value representable in w bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

  // Fibonacci step: shift left, feedback is parity of the tapped bits.
  function automatic logic [63:0] lfsr_next(input logic [63:0] v, input logic [63:0] taps,
                                            input int unsigned w);
    logic [63:0] n;
    n = {v[62:0], ^(v & taps)};
    if (w < 64) begin
      n = n & ((64'd1 << w) - 64'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Reloadable Fibonacci LFSR; a zero seed is replaced by 1 so the register never locks up.
module lfsr_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned         LFSR_W    = 10,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS = 'h240,
  parameter logic [LFSR_W-1:0]   LFSR_SEED = 'h2AA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] SeedFix = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  logic [LFSR_W-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = SeedFix;
    end else if (step) begin
      value_d = LFSR_W'(lfsr_next(64'(value_q), 64'(LFSR_TAPS), LFSR_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= SeedFix;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pulse_frame_gen.sv
// Per-frame BRAM histogram builder: clear, then write cps decaying pulses at LFSR-random
// word addresses, optionally accumulating via read-modify-write.
module pulse_frame_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned       CNT_W     = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       PULSE_LEN = 11,
  parameter int unsigned       PEAK      = 1024,
  parameter bit                ACCUM     = 1'b1,
  parameter int unsigned       RD_LAT    = 1,
  parameter int unsigned       LFSR_W    = 10,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 'h240,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 'h2AA,
  localparam int unsigned      AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cps,
  output logic              bram_en,
  output logic              bram_we,
  output logic [AW+1:0]     bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  event_cnt
);

  localparam int unsigned KW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int unsigned WW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  prev_cps_d, prev_cps_q;
  logic [CNT_W-1:0]  event_cnt_d, event_cnt_q;
  logic [KW-1:0]     k_d, k_q;
  logic [AW-1:0]     base_d, base_q;
  logic [AW-1:0]     clr_d, clr_q;
  logic [WW-1:0]     wait_d, wait_q;
  logic              lfsr_load, lfsr_step, start;
  logic [LFSR_W-1:0] lfsr_val;
  logic [AW-1:0]     word;
  logic [DATA_W-1:0] sample;
  logic              unused_lfsr;

  lfsr_gen #(
    .LFSR_W   (LFSR_W),
    .LFSR_TAPS(LFSR_TAPS),
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .value(lfsr_val)
  );

  assign unused_lfsr = ^lfsr_val;
  // Word index wraps modulo DEPTH through natural AW-bit truncation.
  assign word   = base_q + AW'(k_q);
  assign sample = DATA_W'(pulse_sample(64'(PEAK), 32'(k_q)));

  always_comb begin
    state_d     = state_q;
    prev_cps_d  = prev_cps_q;
    event_cnt_d = event_cnt_q;
    k_d         = k_q;
    base_d      = base_q;
    clr_d       = clr_q;
    wait_d      = wait_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    start       = 1'b0;
    bram_en     = 1'b0;
    bram_we     = 1'b0;
    bram_addr   = '0;
    bram_wdata  = '0;

    // cps changes take priority over any work in progress, abandoning a partial event.
    if (state_q == StIdle) begin
      start = (cps != '0);
    end else if (cps == '0) begin
      state_d     = StIdle;
      event_cnt_d = '0;
    end else if (cps != prev_cps_q) begin
      start = 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          bram_en   = 1'b1;
          bram_we   = 1'b1;
          bram_addr = {clr_q, 2'b00};
          clr_d     = clr_q + AW'(1);
          if (clr_q == AW'(DEPTH - 1)) state_d = StSeed;
        end
        StSeed: begin
          if (event_cnt_q == prev_cps_q) begin
            state_d = StDone;
          end else begin
            base_d    = lfsr_val[AW-1:0];
            lfsr_step = 1'b1;
            k_d       = '0;
            state_d   = ACCUM ? StRd : StWr;
          end
        end
        StRd: begin
          bram_en   = 1'b1;
          bram_addr = {word, 2'b00};
          wait_d    = '0;
          state_d   = (RD_LAT > 1) ? StWait : StWr;
        end
        StWait: begin
          if (wait_q == WW'(RD_LAT - 2)) state_d = StWr;
          else wait_d = wait_q + WW'(1);
        end
        StWr: begin
          bram_en    = 1'b1;
          bram_we    = 1'b1;
          bram_addr  = {word, 2'b00};
          bram_wdata = ACCUM ? DATA_W'(sat_add(64'(bram_rdata), 64'(sample), DATA_W)) : sample;
          if (k_q == KW'(PULSE_LEN - 1)) begin
            event_cnt_d = event_cnt_q + CNT_W'(1);
            state_d     = StSeed;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = ACCUM ? StRd : StWr;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end

    if (start) begin
      state_d     = StClear;
      prev_cps_d  = cps;
      event_cnt_d = '0;
      clr_d       = '0;
      lfsr_load   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_cps_q  <= '0;
      event_cnt_q <= '0;
      k_q         <= '0;
      base_q      <= '0;
      clr_q       <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      prev_cps_q  <= prev_cps_d;
      event_cnt_q <= event_cnt_d;
      k_q         <= k_d;
      base_q      <= base_d;
      clr_q       <= clr_d;
      wait_q      <= wait_d;
    end
  end

  assign busy      = (state_q == StClear) || (state_q == StSeed) || (state_q == StRd) ||
                     (state_q == StWait) || (state_q == StWr);
  assign done      = (state_q == StDone);
  assign event_cnt = event_cnt_q;

endmodule
